// File: rtl/riscv_imm_gen_pipe.sv
// riscv_imm_gen_pipe
// Registered, multi-lane immediate generator for the decode stage. Each beat carries LANES
// instructions. Every lane is classified as R/I/S/B/U/J/Z (CSR zimm), and its immediate is
// sign- or zero-extended to DBUS_DATA_WIDTH bits. The result appears on the outputs one cycle
// after acceptance. The output register and one skid register form a two-entry FIFO.
// Because in_ready depends only on whether the skid register is occupied, fetch never sees
// a combinational path from out_ready.

module riscv_imm_gen_pipe #(
    parameter int IBUS_DATA_WIDTH = 32,
    parameter int DBUS_DATA_WIDTH = 64,
    parameter int LANES           = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [LANES*IBUS_DATA_WIDTH-1:0]   in_instr,
    input  logic [LANES-1:0]                   in_lane_mask,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [LANES*DBUS_DATA_WIDTH-1:0]   out_imm,
    output logic [LANES*7-1:0]                 out_type,
    output logic [LANES-1:0]                   out_lane_mask,
    output logic [LANES-1:0]                   out_illegal
);

    // RV32/RV64 major opcodes recognised by the decoder
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_IMM_32   = 7'b0011011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_OP_32    = 7'b0111011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    // One-hot type codes, ordered {Z,J,U,B,S,I,R} with R at bit 0
    localparam logic [6:0] TYPE_R = 7'b0000001;
    localparam logic [6:0] TYPE_I = 7'b0000010;
    localparam logic [6:0] TYPE_S = 7'b0000100;
    localparam logic [6:0] TYPE_B = 7'b0001000;
    localparam logic [6:0] TYPE_U = 7'b0010000;
    localparam logic [6:0] TYPE_J = 7'b0100000;
    localparam logic [6:0] TYPE_Z = 7'b1000000;

    // Decode result for a single lane
    typedef struct packed {
        logic [DBUS_DATA_WIDTH-1:0] imm;
        logic [6:0]                 kind;
        logic                       illegal;
    } lane_dec_t;

    // Sign-extend a 32-bit value to the output width. This helper is written so that it
    // also works when DBUS_DATA_WIDTH is exactly 32.
    function automatic logic [DBUS_DATA_WIDTH-1:0] sext32(input logic [31:0] value);
        return DBUS_DATA_WIDTH'($signed(value));
    endfunction

    // Classify one instruction and build its immediate. A masked-off lane decodes to all zeros.
    function automatic lane_dec_t decode_lane(input logic [31:0] instr, input logic lane_en);
        lane_dec_t  d;
        logic [6:0] opcode;
        d      = '0;
        opcode = instr[6:0];
        if (lane_en) begin
            case (opcode)
                OP_OP, OP_OP_32: begin
                    d.kind = TYPE_R;
                end
                OP_LOAD, OP_MISC_MEM, OP_IMM, OP_IMM_32, OP_JALR: begin
                    d.kind = TYPE_I;
                    d.imm  = sext32({{20{instr[31]}}, instr[31:20]});
                end
                OP_SYSTEM: begin
                    if (instr[14]) begin
                        d.kind = TYPE_Z;
                        d.imm  = DBUS_DATA_WIDTH'(instr[19:15]);
                    end else begin
                        d.kind = TYPE_I;
                        d.imm  = sext32({{20{instr[31]}}, instr[31:20]});
                    end
                end
                OP_STORE: begin
                    d.kind = TYPE_S;
                    d.imm  = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
                end
                OP_BRANCH: begin
                    d.kind = TYPE_B;
                    d.imm  = sext32({{19{instr[31]}}, instr[31], instr[7],
                                     instr[30:25], instr[11:8], 1'b0});
                end
                OP_LUI, OP_AUIPC: begin
                    d.kind = TYPE_U;
                    d.imm  = sext32({instr[31:12], 12'b0});
                end
                OP_JAL: begin
                    d.kind = TYPE_J;
                    d.imm  = sext32({{11{instr[31]}}, instr[31], instr[19:12],
                                     instr[20], instr[30:21], 1'b0});
                end
                default: begin
                    d.illegal = 1'b1;
                end
            endcase
        end
        return d;
    endfunction

    logic [LANES*DBUS_DATA_WIDTH-1:0] dec_imm;
    logic [LANES*7-1:0]               dec_type;
    logic [LANES-1:0]                 dec_illegal;
    lane_dec_t                        lane_dec;

    logic                             skid_valid;
    logic [LANES*DBUS_DATA_WIDTH-1:0] skid_imm;
    logic [LANES*7-1:0]               skid_type;
    logic [LANES-1:0]                 skid_lane_mask;
    logic [LANES-1:0]                 skid_illegal;

    logic                             accept;

    // Ready depends only on reset and skid occupancy, so there is no path from out_ready
    assign in_ready = ~rst & ~skid_valid;
    assign accept   = in_valid & in_ready;

    // Decode every lane of the incoming bundle independently
    always_comb begin
        dec_imm     = '0;
        dec_type    = '0;
        dec_illegal = '0;
        lane_dec    = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_dec = decode_lane(in_instr[k*IBUS_DATA_WIDTH +: 32], in_lane_mask[k]);
            dec_imm[k*DBUS_DATA_WIDTH +: DBUS_DATA_WIDTH] = lane_dec.imm;
            dec_type[k*7 +: 7]                            = lane_dec.kind;
            dec_illegal[k]                                = lane_dec.illegal;
        end
    end

    // Two-entry FIFO made of the output register and the skid register. The skid register
    // always holds the younger bundle, so it refills the output before new input does.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_imm        <= '0;
            out_type       <= '0;
            out_lane_mask  <= '0;
            out_illegal    <= '0;
            skid_valid     <= 1'b0;
            skid_imm       <= '0;
            skid_type      <= '0;
            skid_lane_mask <= '0;
            skid_illegal   <= '0;
        end else begin
            if (!out_valid || out_ready) begin
                if (skid_valid) begin
                    out_valid     <= 1'b1;
                    out_imm       <= skid_imm;
                    out_type      <= skid_type;
                    out_lane_mask <= skid_lane_mask;
                    out_illegal   <= skid_illegal;
                    skid_valid    <= 1'b0;
                end else if (accept) begin
                    out_valid     <= 1'b1;
                    out_imm       <= dec_imm;
                    out_type      <= dec_type;
                    out_lane_mask <= in_lane_mask;
                    out_illegal   <= dec_illegal;
                end else begin
                    out_valid     <= 1'b0;
                end
            end else if (accept) begin
                skid_valid     <= 1'b1;
                skid_imm       <= dec_imm;
                skid_type      <= dec_type;
                skid_lane_mask <= in_lane_mask;
                skid_illegal   <= dec_illegal;
            end
        end
    end

endmodule

// File: tb/tb_riscv_imm_gen_pipe.sv
// tb_riscv_imm_gen_pipe
// Table-driven bench for the two-lane immediate generator. It also runs hand-written
// sequences that exercise backpressure through the skid buffer and a reset that arrives
// while both stages are full.

module tb_riscv_imm_gen_pipe;

    localparam logic [6:0] TY_R = 7'h01;
    localparam logic [6:0] TY_I = 7'h02;
    localparam logic [6:0] TY_S = 7'h04;
    localparam logic [6:0] TY_B = 7'h08;
    localparam logic [6:0] TY_U = 7'h10;
    localparam logic [6:0] TY_J = 7'h20;
    localparam logic [6:0] TY_Z = 7'h40;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_instr;
    logic [1:0]   in_lane_mask;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_imm;
    logic [13:0]  out_type;
    logic [1:0]   out_lane_mask;
    logic [1:0]   out_illegal;

    int num_checks;
    int num_errors;

    typedef struct {
        string       name;
        logic [31:0] instr0;
        logic [31:0] instr1;
        logic [1:0]  mask;
        logic [63:0] exp_imm0;
        logic [63:0] exp_imm1;
        logic [6:0]  exp_type0;
        logic [6:0]  exp_type1;
        logic [1:0]  exp_illegal;
    } vec_t;

    vec_t vecs[$];
    int   exp_q[$];

    riscv_imm_gen_pipe #(
        .IBUS_DATA_WIDTH(32),
        .DBUS_DATA_WIDTH(64),
        .LANES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_instr(in_instr),
        .in_lane_mask(in_lane_mask),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_imm(out_imm),
        .out_type(out_type),
        .out_lane_mask(out_lane_mask),
        .out_illegal(out_illegal)
    );

    // Free-running 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        in_valid     = 1'b1;
        in_instr     = {v.instr1, v.instr0};
        in_lane_mask = v.mask;
    endtask

    task automatic checkOutput(input vec_t v);
        checkValue({v.name, "_out_valid"}, 64'(out_valid), 64'(1'b1));
        checkValue({v.name, "_imm0"}, out_imm[63:0], v.exp_imm0);
        checkValue({v.name, "_imm1"}, out_imm[127:64], v.exp_imm1);
        checkValue({v.name, "_type0"}, 64'(out_type[6:0]), 64'(v.exp_type0));
        checkValue({v.name, "_type1"}, 64'(out_type[13:7]), 64'(v.exp_type1));
        checkValue({v.name, "_illegal"}, 64'(out_illegal), 64'(v.exp_illegal));
        checkValue({v.name, "_lane_mask"}, 64'(out_lane_mask), 64'(v.mask));
    endtask

    function automatic logic [31:0] addiTag(input int tag);
        return {12'(tag), 5'd0, 3'b000, 5'd1, 7'b0010011};
    endfunction

    // Main test sequence
    initial begin
        int  next_tag;
        int  popped;
        bit  done;
        bit  acc;
        bit  drn;

        num_checks = 0;
        num_errors = 0;

        vecs.push_back(vec_t'{"t1_addi_m1", 32'hFFF00093, 32'h00000000, 2'b01,
                              64'hFFFF_FFFF_FFFF_FFFF, 64'h0, TY_I, 7'h00, 2'b00});
        vecs.push_back(vec_t'{"t2_lui_pair", 32'h123450B7, 32'h800000B7, 2'b11,
                              64'h0000_0000_1234_5000, 64'hFFFF_FFFF_8000_0000, TY_U, TY_U, 2'b00});
        vecs.push_back(vec_t'{"t3_beq_csrrwi", 32'hFE000EE3, 32'h300FD073, 2'b11,
                              64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_001F, TY_B, TY_Z, 2'b00});
        vecs.push_back(vec_t'{"t4_illegal_pair", 32'h0000007F, 32'h00000000, 2'b11,
                              64'h0, 64'h0, 7'h00, 7'h00, 2'b11});
        vecs.push_back(vec_t'{"sw_jal", 32'hFE512C23, 32'h001000EF, 2'b11,
                              64'hFFFF_FFFF_FFFF_FFF8, 64'h0000_0000_0000_0800, TY_S, TY_J, 2'b00});
        vecs.push_back(vec_t'{"add_masked_illegal", 32'h00B50533, 32'h0000007F, 2'b01,
                              64'h0, 64'h0, TY_R, 7'h00, 2'b00});
        vecs.push_back(vec_t'{"csrrw_auipc", 32'h80001073, 32'hFFFFF097, 2'b11,
                              64'hFFFF_FFFF_FFFF_F800, 64'hFFFF_FFFF_FFFF_F000, TY_I, TY_U, 2'b00});
        vecs.push_back(vec_t'{"lane1_jal_neg", 32'hFFF00093, 32'hFFFFF0EF, 2'b10,
                              64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 7'h00, TY_J, 2'b00});
        vecs.push_back(vec_t'{"lw_fence", 32'h7FF12083, 32'h0FF0000F, 2'b11,
                              64'h0000_0000_0000_07FF, 64'h0000_0000_0000_00FF, TY_I, TY_I, 2'b00});

        rst          = 1'b1;
        in_valid     = 1'b0;
        in_instr     = '0;
        in_lane_mask = '0;
        out_ready    = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkValue("rst_out_valid", 64'(out_valid), 64'(1'b0));
        checkValue("rst_in_ready", 64'(in_ready), 64'(1'b0));
        checkValue("rst_out_imm_lo", out_imm[63:0], 64'h0);
        checkValue("rst_out_imm_hi", out_imm[127:64], 64'h0);
        checkValue("rst_out_type", 64'(out_type), 64'h0);
        checkValue("rst_out_lane_mask", 64'(out_lane_mask), 64'h0);
        checkValue("rst_out_illegal", 64'(out_illegal), 64'h0);

        rst = 1'b0;
        #1;
        checkValue("post_rst_in_ready", 64'(in_ready), 64'(1'b1));

        // Back-to-back vectors with the consumer always ready
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkValue({vecs[i].name, "_in_ready"}, 64'(in_ready), 64'(1'b1));
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            checkOutput(vecs[i]);
        end
        @(posedge clk);
        #1;
        checkValue("idle_out_valid", 64'(out_valid), 64'(1'b0));

        // Tagged stream with three stalled cycles, then release
        next_tag = 1;
        popped   = 0;
        done     = 1'b0;
        exp_q.delete();
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            out_ready    = (cyc >= 3);
            in_valid     = (next_tag <= 6);
            in_instr     = {32'h0, addiTag(next_tag)};
            in_lane_mask = 2'b01;
            checkValue("t5_out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            checkValue("t5_in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
            if (out_valid && exp_q.size() != 0)
                checkValue("t5_out_imm", out_imm[63:0], 64'(exp_q[0]));
            acc = in_valid && in_ready;
            drn = out_valid && out_ready;
            @(posedge clk);
            #1;
            if (drn && exp_q.size() != 0) begin
                exp_q.delete(0);
                popped++;
            end
            if (acc) begin
                exp_q.push_back(next_tag);
                next_tag++;
            end
            if (cyc == 2)
                checkValue("t5_accepted_in_stall", 64'(next_tag - 1), 64'd2);
            if (next_tag > 6 && exp_q.size() == 0)
                done = 1'b1;
        end
        in_valid = 1'b0;
        checkValue("t5_done_in_budget", 64'(done), 64'(1'b1));
        checkValue("t5_drained_count", 64'(popped), 64'd6);

        // Fill both stages, then reset
        out_ready = 1'b0;
        for (int t = 7; t <= 8; t++) begin
            in_valid     = 1'b1;
            in_instr     = {32'h0, addiTag(t)};
            in_lane_mask = 2'b01;
            @(posedge clk);
            #1;
        end
        checkValue("t6_full_in_ready", 64'(in_ready), 64'(1'b0));
        checkValue("t6_full_out_valid", 64'(out_valid), 64'(1'b1));
        rst = 1'b1;
        #1;
        checkValue("t6_rst_in_ready_now", 64'(in_ready), 64'(1'b0));
        @(posedge clk);
        #1;
        checkValue("t6_rst_out_valid", 64'(out_valid), 64'(1'b0));
        checkValue("t6_rst_in_ready", 64'(in_ready), 64'(1'b0));
        checkValue("t6_rst_out_imm", out_imm[63:0], 64'h0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checkValue("t6_release_in_ready", 64'(in_ready), 64'(1'b1));
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            checkValue("t6_no_stale_out_valid", 64'(out_valid), 64'(1'b0));
        end

        $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
        $finish;
    end

endmodule
